up_state_ctrl: RTL and testbench
================================

UP_STATE_CTRL -- requirements
Module: up_state_ctrl

Interface
REQ-001 Parameters SHALL be BOOT_WORDS, default 16'd1024, count of words copied from storage at boot, legal range 1..32768.
REQ-002 Parameters SHALL include DEBOUNCE_CYCLES, default 16'd50000, consecutive stable cycles required to accept a button level.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports SHALL be, in order:
  i_clk  in  1  sole clock, all state on rising edge
  i_rst  in  1  asynchronous active-high reset
  i_pauseBtn  in  1  raw asynchronous pause/resume button
  i_coreHLT  in  1  core reports HLT in execute
  i_smNowPaused  in  1  core confirms paused state
  o_smIsBooted  out  1  boot copy complete
  o_smStartPause  out  1  request/hold core pause
  o_stoReq  out  1  storage read request
  o_stoAddr  out  15  storage word address
  i_stoAck  in  1  storage data valid, one-cycle pulse
  i_stoData  in  16  storage read data
  o_bootOwnsMem  out  1  1 = this block drives memory port
  o_memAddr  out  16  boot write address
  o_memDataOut  out  16  boot write data
  o_memWr  out  1  boot write strobe
  o_state  out  3  current state encoding

Function
REQ-005 States SHALL be BOOT_REQ=0, BOOT_WR=1, RUN=2, PAUSING=3, PAUSED=4; o_state SHALL equal the state register.
REQ-006 BOOT_REQ: o_stoReq=1, o_stoAddr=word counter; on i_stoAck latch i_stoData and go to BOOT_WR next cycle.
REQ-007 BOOT_WR: o_memWr=1 for exactly one cycle, o_memAddr={1'b0,counter}, o_memDataOut=latched data, o_stoReq=0.
REQ-008 Leaving BOOT_WR: if counter==BOOT_WORDS-1, go to RUN; else increment counter and return to BOOT_REQ.
REQ-009 o_bootOwnsMem SHALL be 1 in BOOT_REQ/BOOT_WR and 0 otherwise; o_memWr, o_memAddr, o_memDataOut SHALL be 0 whenever o_bootOwnsMem=0.
REQ-010 o_smIsBooted SHALL be 0 in boot states and 1 in RUN, PAUSING, PAUSED.
REQ-011 i_pauseBtn SHALL pass a 2-flop synchronizer, then a debouncer updating its filtered level only after DEBOUNCE_CYCLES identical consecutive synchronized samples.
REQ-012 A "press" SHALL be a one-cycle pulse on a 0->1 transition of the filtered level.
REQ-013 RUN: press or i_coreHLT=1 SHALL go to PAUSING next cycle; simultaneous press and HLT SHALL produce one transition.
REQ-014 PAUSING: o_smStartPause=1; when i_smNowPaused=1, go to PAUSED.
REQ-015 PAUSED: o_smStartPause SHALL stay 1; a press SHALL go to RUN, deasserting o_smStartPause that cycle.
REQ-016 Presses in BOOT_REQ, BOOT_WR and PAUSING SHALL be discarded, not queued.
REQ-017 i_stoAck outside BOOT_REQ SHALL be ignored.
REQ-018 i_coreHLT SHALL be ignored outside RUN.

Reset
REQ-019 On i_rst=1, independent of clock: state=BOOT_REQ, counter=0, latched data=0, synchronizer and debouncer filtered level=0, debounce count=0.
REQ-020 Output values while reset is active: o_stoReq=1, o_stoAddr=0, o_bootOwnsMem=1, o_smIsBooted=0, o_smStartPause=0, o_memWr=0, o_state=0.
REQ-021 Reset asserted mid-boot or mid-pause SHALL abort the operation and restart the copy from address 0 after release.

Verification
REQ-022 BOOT_WORDS=4, ack 2 cycles after each request, data 0xA000+addr -> four o_memWr pulses at addresses 0..3 with data 0xA000..0xA003, then o_smIsBooted=1 and o_state=2.
REQ-023 DEBOUNCE_CYCLES=3, in RUN: button high for 2 cycles then low -> no state change; button high for 6 cycles -> o_smStartPause=1; i_smNowPaused=1 one cycle later -> o_state=4.
REQ-024 In PAUSED: release button, then press again for 6 cycles -> o_state=2 and o_smStartPause=0; i_coreHLT=1 in RUN -> o_state=3 on the next cycle.
REQ-025 Press button during boot word 2 -> copy completes normally and state=RUN with no pause; spurious i_stoAck in BOOT_WR -> no extra write and counter unchanged.
REQ-026 Assert i_rst in PAUSED and during word 3 of the copy -> outputs match REQ-020 immediately; after release the copy restarts at o_stoAddr=0.

Source files
------------

// File: rtl/up_state_ctrl.sv
// up_state_ctrl: copies BOOT_WORDS words from storage into memory after reset,
// then arbitrates core pause/resume from a debounced push button and core HLT.
module up_state_ctrl #(
  parameter logic [15:0] BOOT_WORDS      = 16'd1024,  // legal range 1..32768
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pauseBtn,
  input  logic        i_coreHLT,
  input  logic        i_smNowPaused,
  output logic        o_smIsBooted,
  output logic        o_smStartPause,
  output logic        o_stoReq,
  output logic [14:0] o_stoAddr,
  input  logic        i_stoAck,
  input  logic [15:0] i_stoData,
  output logic        o_bootOwnsMem,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memDataOut,
  output logic        o_memWr,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    BOOT_REQ = 3'd0,
    BOOT_WR  = 3'd1,
    RUN      = 3'd2,
    PAUSING  = 3'd3,
    PAUSED   = 3'd4
  } state_e;

  // BOOT_WORDS = 32768 wraps to 0 in 15 bits, so the last index is still 0x7FFF.
  localparam logic [14:0] LAST_WORD = BOOT_WORDS[14:0] - 15'd1;
  localparam logic [15:0] DB_LAST   = DEBOUNCE_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;

  logic        sync1_q, sync2_q;
  logic        filt_q, filt_d;
  logic        filt_dly_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        press;

  // Button path: two-flop synchronizer, debounce counter, filtered level history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge inputs;
      // blocking ones here would collapse the synchronizer into a single stage.
      sync1_q    <= i_pauseBtn;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  // One-cycle press pulse on the first cycle the filtered level reads high.
  assign press = filt_q & ~filt_dly_q;

  // Controller state, boot word counter and latched storage data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= BOOT_REQ;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state and output decode; presses outside RUN/PAUSED fall through unused.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    o_stoReq       = 1'b0;
    o_stoAddr      = '0;
    o_bootOwnsMem  = 1'b0;
    o_memWr        = 1'b0;
    o_memAddr      = '0;
    o_memDataOut   = '0;
    o_smIsBooted   = 1'b1;
    o_smStartPause = 1'b0;

    unique case (state_q)
      BOOT_REQ: begin
        o_stoReq      = 1'b1;
        o_stoAddr     = cnt_q;
        o_bootOwnsMem = 1'b1;
        o_smIsBooted  = 1'b0;
        if (i_stoAck) begin
          data_d  = i_stoData;
          state_d = BOOT_WR;
        end
      end
      BOOT_WR: begin
        o_bootOwnsMem = 1'b1;
        o_smIsBooted  = 1'b0;
        o_memWr       = 1'b1;
        o_memAddr     = {1'b0, cnt_q};
        o_memDataOut  = data_q;
        if (cnt_q == LAST_WORD) begin
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q + 15'd1;
          state_d = BOOT_REQ;
        end
      end
      RUN: begin
        if (press || i_coreHLT) state_d = PAUSING;
      end
      PAUSING: begin
        o_smStartPause = 1'b1;
        if (i_smNowPaused) state_d = PAUSED;
      end
      PAUSED: begin
        o_smStartPause = ~press;
        if (press) state_d = RUN;
      end
      default: state_d = BOOT_REQ;
    endcase
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_up_state_ctrl.sv
// tb_up_state_ctrl: directed sequence with randomized storage latency/data and
// button pulse lengths, checked against a behavioural model of the controller.
module tb_up_state_ctrl;

  localparam int NW = 4;   // boot words
  localparam int DB = 3;   // debounce cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        btn, hlt, now_paused;
  logic        sto_ack;
  logic [15:0] sto_data;
  logic        o_smIsBooted, o_smStartPause, o_stoReq, o_bootOwnsMem, o_memWr;
  logic [14:0] o_stoAddr;
  logic [15:0] o_memAddr, o_memDataOut;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;

  // Storage model contents and environment knobs.
  logic [15:0] sto_mem [NW];
  bit          ack_rand    = 1'b0;
  bit          spurious_en = 1'b0;
  logic [31:0] wr_q [$];   // observed writes {addr, data}

  up_state_ctrl #(.BOOT_WORDS(16'(NW)), .DEBOUNCE_CYCLES(16'(DB))) dut (
    .i_clk(clk), .i_rst(rst), .i_pauseBtn(btn), .i_coreHLT(hlt),
    .i_smNowPaused(now_paused), .o_smIsBooted(o_smIsBooted),
    .o_smStartPause(o_smStartPause), .o_stoReq(o_stoReq), .o_stoAddr(o_stoAddr),
    .i_stoAck(sto_ack), .i_stoData(sto_data), .o_bootOwnsMem(o_bootOwnsMem),
    .o_memAddr(o_memAddr), .o_memDataOut(o_memDataOut), .o_memWr(o_memWr),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Advance n cycles, landing 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Storage: answer each request after a latency with one-cycle ack pulse;
  // optionally fire a stray ack while the controller is writing.
  initial begin : storage
    bit          pending = 1'b0;
    int          lat = 0;
    logic [14:0] addr = '0;
    sto_ack  = 1'b0;
    sto_data = '0;
    forever begin
      cyc(1);
      sto_ack = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (pending) begin
        if (lat == 0) begin
          sto_ack  = 1'b1;
          sto_data = sto_mem[addr[1:0]];
          pending  = 1'b0;
        end else begin
          lat--;
        end
      end else if (o_stoReq && o_state == 3'd0) begin
        pending = 1'b1;
        addr    = o_stoAddr;
        lat     = ack_rand ? int'($urandom_range(0, 3)) : 1;
      end else if (spurious_en && o_state == 3'd1) begin
        sto_ack  = 1'b1;
        sto_data = 16'hDEAD;
      end
    end
  end

  // Write monitor: record every memory write strobe.
  initial begin : wr_mon
    forever begin
      cyc(1);
      if (o_memWr) wr_q.push_back({o_memAddr, o_memDataOut});
    end
  end

  // Expected outputs whenever reset is held.
  task automatic check_reset_outputs(input string tag);
    check({tag, ".stoReq"},     32'(o_stoReq),       32'd1);
    check({tag, ".stoAddr"},    32'(o_stoAddr),      32'd0);
    check({tag, ".ownsMem"},    32'(o_bootOwnsMem),  32'd1);
    check({tag, ".booted"},     32'(o_smIsBooted),   32'd0);
    check({tag, ".startPause"}, 32'(o_smStartPause), 32'd0);
    check({tag, ".memWr"},      32'(o_memWr),        32'd0);
    check({tag, ".state"},      32'(o_state),        32'd0);
  endtask

  // Assert reset between clock edges, check outputs at once, release, check restart.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    wr_q.delete();
    cyc(3);
    #2 rst = 1'b0;
    cyc(1);
    check({tag, ".restartReq"},  32'(o_stoReq),  32'd1);
    check({tag, ".restartAddr"}, 32'(o_stoAddr), 32'd0);
  endtask

  task automatic wait_word(input string tag, input int a);
    int n = 0;
    while (!(o_stoReq && o_stoAddr == 15'(a)) && n < 100) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(o_stoReq && o_stoAddr == 15'(a)), 32'd1);
  endtask

  // Model: after boot, memory holds exactly the storage image, in address order.
  task automatic wait_boot(input string tag);
    int n = 0;
    while (!o_smIsBooted && n < 200) begin
      cyc(1);
      n++;
    end
    check({tag, ".booted"}, 32'(o_smIsBooted), 32'd1);
    check({tag, ".state"},  32'(o_state), 32'd2);
    check({tag, ".nwrites"}, 32'(wr_q.size()), 32'(NW));
    for (int i = 0; i < NW && i < wr_q.size(); i++) begin
      check($sformatf("%s.wr%0d", tag, i), wr_q[i], {16'(i), sto_mem[i]});
    end
    check({tag, ".ownsMem"}, 32'(o_bootOwnsMem), 32'd0);
    check({tag, ".memBus"},  {o_memAddr, o_memDataOut}, 32'd0);
    check({tag, ".memWr"},   32'(o_memWr), 32'd0);
    check({tag, ".stoReq"},  32'(o_stoReq), 32'd0);
  endtask

  // Hold the button k cycles then let it settle low; notes whether the
  // pause request was dropped while still PAUSED (same-cycle resume).
  bit saw_early_drop;
  task automatic button_pulse(input int k);
    saw_early_drop = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < k; i++) begin
      cyc(1);
      if (o_state == 3'd4 && !o_smStartPause) saw_early_drop = 1'b1;
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (o_state == 3'd4 && !o_smStartPause) saw_early_drop = 1'b1;
    end
  endtask

  // A pulse is a press only if it yields DEBOUNCE consecutive high samples.
  function automatic bit is_press(input int k);
    return k >= DB;
  endfunction

  initial begin : main
    int k;
    rst = 1'b1; btn = 1'b0; hlt = 1'b0; now_paused = 1'b0;
    for (int i = 0; i < NW; i++) sto_mem[i] = 16'hA000 + 16'(i);

    cyc(3);
    check_reset_outputs("por");
    #2 rst = 1'b0;
    cyc(1);

    // First boot: fixed 2-cycle ack latency, button pressed during word 2.
    wait_word("boot1.word2", 2);
    button_pulse(8);
    wait_boot("boot1");
    cyc(10);
    check("boot1.noPause", 32'(o_state), 32'd2);
    check("boot1.noStart", 32'(o_smStartPause), 32'd0);

    // Short glitches in RUN are filtered out.
    button_pulse(2);
    check("glitch2.state", 32'(o_state), 32'd2);
    k = int'($urandom_range(1, DB - 1));
    button_pulse(k);
    check($sformatf("glitch%0d.state", k), 32'(o_state),
          is_press(k) ? 32'd3 : 32'd2);

    // Real press in RUN: request pause.
    k = int'($urandom_range(DB, 6));
    button_pulse(k);
    check($sformatf("press%0d.state", k), 32'(o_state), is_press(k) ? 32'd3 : 32'd2);
    check("pausing.startPause", 32'(o_smStartPause), 32'd1);

    // Press and HLT while PAUSING are ignored.
    hlt = 1'b1;
    button_pulse(6);
    hlt = 1'b0;
    check("pausing.pressIgnored", 32'(o_state), 32'd3);

    now_paused = 1'b1;
    cyc(1);
    now_paused = 1'b0;
    check("paused.state", 32'(o_state), 32'd4);
    check("paused.startPause", 32'(o_smStartPause), 32'd1);
    hlt = 1'b1;
    cyc(3);
    hlt = 1'b0;
    check("paused.hltIgnored", 32'(o_state), 32'd4);

    // Resume from PAUSED by a press; pause request drops in the press cycle.
    button_pulse(6);
    check("resume.state", 32'(o_state), 32'd2);
    check("resume.startPause", 32'(o_smStartPause), 32'd0);
    check("resume.earlyDrop", 32'(saw_early_drop), 32'd1);

    // HLT in RUN: PAUSING on the next cycle.
    hlt = 1'b1;
    cyc(1);
    check("hlt.state", 32'(o_state), 32'd3);
    hlt = 1'b0;
    now_paused = 1'b1;
    cyc(1);
    now_paused = 1'b0;
    check("hlt.paused", 32'(o_state), 32'd4);

    // Reset while PAUSED; reboot with random data/latency and stray acks.
    for (int i = 0; i < NW; i++) sto_mem[i] = 16'($urandom);
    ack_rand    = 1'b1;
    spurious_en = 1'b1;
    do_reset("rstPaused");
    wait_boot("boot2");
    spurious_en = 1'b0;

    // Reset during word 3 of the copy.
    for (int i = 0; i < NW; i++) sto_mem[i] = 16'($urandom);
    do_reset("rstIdle");
    wait_word("boot3.word3", 3);
    do_reset("rstWord3");
    wait_boot("boot3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
